// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an SPI controller and the register-bank target.
// The controller drives clock, select and data-in; the target drives data-out.
interface spi_reg_bank_if;
    logic spi_clk;
    logic spi_sel;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_sel,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_sel,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 LSB-first target with an integrated register bank, fully in the clk domain.
// Define SPI_REG_BANK_AUTO_INC_EN for address auto-increment bursts within one select window.
module spi_reg_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CMD_WIDTH  = 8,
    parameter int NUM_REGS   = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_reg_bank_if.slave                  spi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    output logic [NUM_REGS-1:0]            reg_wr_stb,
    output logic                           busy
);
    localparam int MAXW = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic                  sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                  sel_s1_q, sel_s2_q;
    logic                  mosi_s1_q, mosi_s2_q;
    logic                  armed_q, armed_d;
    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MAXW-1:0]       sh_q, sh_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic [NUM_REGS-1:0]   stb_q, stb_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] word;
    logic                  sclk_rise, sclk_fall;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

    // Unimplemented addresses read back as zero.
    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_WIDTH'(i)) r = regs_q[i];
        end
        return r;
    endfunction

`ifdef SPI_REG_BANK_AUTO_INC_EN
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a >= ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        regs_d  = regs_q;
        stb_d   = '0;
        word    = '0;
        armed_d = armed_q | sel_s2_q;

        case (state_q)
            S_IDLE: begin
                if (armed_q && !sel_s2_q) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    sh_d[cnt_q] = mosi_s2_q;
                    if (cnt_q == CW'(CMD_WIDTH - 1)) begin
                        dir_d   = sh_d[0];
                        addr_d  = sh_d[ADDR_WIDTH:1];
                        tx_d    = rd_word(sh_d[ADDR_WIDTH:1]);
                        state_d = S_DATA;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (sclk_fall && !dir_q) begin
                    miso_d = tx_q[0];
                    tx_d   = tx_q >> 1;
                end
                if (sclk_rise) begin
                    sh_d[cnt_q] = mosi_s2_q;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        word = sh_d[DATA_WIDTH-1:0];
                        if (dir_q) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == ADDR_WIDTH'(i)) begin
                                    regs_d[i] = word;
                                    stb_d[i]  = 1'b1;
                                end
                            end
                        end
                        cnt_d = '0;
                        sh_d  = '0;
`ifdef SPI_REG_BANK_AUTO_INC_EN
                        addr_d = next_addr(addr_q);
                        tx_d   = rd_word(next_addr(addr_q));
`else
                        state_d = S_CMD;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Deselect abandons any partial word, including one completing this cycle.
        if (sel_s2_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            stb_d   = '0;
            regs_d  = regs_q;
        end
        if (state_d != S_DATA) miso_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            sel_s1_q  <= 1'b0;
            sel_s2_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            stb_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sclk_s1_q <= spi.spi_clk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            sel_s1_q  <= spi.spi_sel;
            sel_s2_q  <= sel_s1_q;
            mosi_s1_q <= spi.spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            stb_q     <= stb_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign reg_wr_stb   = stb_q;
    assign spi.spi_miso = miso_q;
    // Selection only counts once sel has been seen high since reset.
    assign busy         = armed_q & ~sel_s2_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: SPI frames at clk/8, expected
// commits and read words queued by stimulus, popped by a monitor.
module tb_spi_reg_bank;
    logic        clk;
    logic        rst;
    logic [47:0] reg_data;
    logic [5:0]  reg_wr_stb;
    logic        busy;

    spi_reg_bank_if spi_if ();

    spi_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_if.slave),
        .reg_data   (reg_data),
        .reg_wr_stb (reg_wr_stb),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_regs [6];
    logic [5:0]  wr_exp_stb [$];
    logic [47:0] wr_exp_data [$];
    logic [7:0]  rd_exp [$];
    logic [7:0]  rd_obs [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model_data();
        logic [47:0] d;
        for (int i = 0; i < 6; i++) d[i*8 +: 8] = exp_regs[i];
        return d;
    endfunction

    task automatic exp_write(input int a, input logic [7:0] v);
        if (a < 6) begin
            exp_regs[a] = v;
            wr_exp_stb.push_back(6'(1 << a));
            wr_exp_data.push_back(model_data());
        end
    endtask

    task automatic send(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_if.spi_mosi = v[i];
            #40;
            spi_if.spi_clk = 1'b1;
            rx[i] = spi_if.spi_miso;
            #40;
            spi_if.spi_clk = 1'b0;
        end
    endtask

    task automatic sel_low();
        spi_if.spi_sel = 1'b0;
        #40;
    endtask

    task automatic sel_high();
        #40;
        spi_if.spi_sel = 1'b1;
        #100;
    endtask

    task automatic wr_word(input logic [7:0] cmd, input logic [7:0] d);
        logic [7:0] rx;
        exp_write(int'(cmd[3:1]), d);
        send(cmd, 8, rx);
        send(d, 8, rx);
    endtask

    task automatic rd_frame(input logic [7:0] cmd, input logic [7:0] expv);
        logic [7:0] rx;
        rd_exp.push_back(expv);
        sel_low();
        send(cmd, 8, rx);
        send(8'h00, 8, rx);
        rd_obs.push_back(rx);
        sel_high();
    endtask

    // Monitor: every strobe and every completed read word is matched against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (reg_wr_stb != '0) begin
                if (wr_exp_stb.size() == 0) begin
                    chk("unexpected_strobe", 64'(reg_wr_stb), 64'h0);
                end else begin
                    chk("wr_stb", 64'(reg_wr_stb), 64'(wr_exp_stb.pop_front()));
                    chk("wr_data", 64'(reg_data), 64'(wr_exp_data.pop_front()));
                end
            end
            if (rd_obs.size() > 0) begin
                if (rd_exp.size() == 0)
                    chk("unexpected_read", 64'(rd_obs.pop_front()), 64'h0);
                else
                    chk("rd_word", 64'(rd_obs.pop_front()), 64'(rd_exp.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 6; i++) exp_regs[i] = '0;
        spi_if.spi_clk  = 1'b0;
        spi_if.spi_sel  = 1'b1;
        spi_if.spi_mosi = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_reg_data", 64'(reg_data), 64'h0);
        chk("rst_stb", 64'(reg_wr_stb), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_miso", 64'(spi_if.spi_miso), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write 0xA5 to reg 2
        sel_low();
        chk("busy_sel_low", 64'(busy), 64'h1);
        wr_word(8'h05, 8'hA5);
        sel_high();
        chk("busy_sel_high", 64'(busy), 64'h0);

        // 2: read reg 2 back
        rd_frame(8'h04, 8'hA5);
        chk("t2_regs", 64'(reg_data), 64'(model_data()));

        // 3: out-of-range write is dropped, read returns zero
        sel_low();
        send(8'h0F, 8, rx);
        send(8'hFF, 8, rx);
        sel_high();
        chk("t3_regs", 64'(reg_data), 64'(model_data()));
        rd_frame(8'h0E, 8'h00);

        // 4: abort after 4 data bits, then a complete write
        sel_low();
        send(8'h03, 8, rx);
        send(8'h3C, 4, rx);
        sel_high();
        chk("t4_abort_regs", 64'(reg_data), 64'(model_data()));
        sel_low();
        wr_word(8'h03, 8'h3C);
        sel_high();
        chk("t4_reg1", 64'(reg_data[15:8]), 64'h3C);

`ifdef SPI_REG_BANK_AUTO_INC_EN
        // 6: burst from reg 5 wraps to reg 0
        sel_low();
        exp_write(5, 8'h11);
        send(8'h0B, 8, rx);
        send(8'h11, 8, rx);
        exp_write(0, 8'h22);
        send(8'h22, 8, rx);
        sel_high();
        chk("t6_reg5", 64'(reg_data[47:40]), 64'h11);
        chk("t6_reg0", 64'(reg_data[7:0]), 64'h22);
`else
        // 5: two commands in one select window
        sel_low();
        wr_word(8'h03, 8'h11);
        wr_word(8'h05, 8'h22);
        sel_high();
        chk("t5_reg1", 64'(reg_data[15:8]), 64'h11);
        chk("t5_reg2", 64'(reg_data[23:16]), 64'h22);
`endif

        // Reset mid-frame clears everything and stays idle until a new select
        sel_low();
        send(8'h05, 8, rx);
        send(8'h07, 3, rx);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) exp_regs[i] = '0;
        repeat (2) @(negedge clk);
        chk("midrst_regs", 64'(reg_data), 64'h0);
        chk("midrst_miso", 64'(spi_if.spi_miso), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        send(8'h00, 5, rx);
        send(8'hFF, 8, rx);
        chk("postrst_busy", 64'(busy), 64'h0);
        sel_high();
        chk("postrst_regs", 64'(reg_data), 64'h0);

        // Recovery after reset
        sel_low();
        wr_word(8'h09, 8'h5A);
        sel_high();
        chk("recover_reg4", 64'(reg_data[39:32]), 64'h5A);
        rd_frame(8'h08, 8'h5A);

        repeat (10) @(negedge clk);
        chk("wr_queue_empty", 64'(wr_exp_stb.size()), 64'h0);
        chk("rd_queue_empty", 64'(rd_exp.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
